// File: rtl/input_pio_pkg.sv
// rtl/input_pio_pkg.sv - register addresses and edge-mode types for the input PIO
package input_pio_pkg;

    localparam logic [1:0] ADDR_DATA     = 2'd0;
    localparam logic [1:0] ADDR_IRQMASK  = 2'd1;
    localparam logic [1:0] ADDR_RESERVED = 2'd2;
    localparam logic [1:0] ADDR_EDGECAP  = 2'd3;

    typedef enum logic [1:0] {
        EDGE_RISE = 2'd0,
        EDGE_FALL = 2'd1,
        EDGE_ANY  = 2'd2
    } edge_mode_e;

    // One bit of edge detection between the filtered value and its delayed copy.
    function automatic logic edge_hit(input logic cur, input logic prev, input edge_mode_e mode);
        case (mode)
            EDGE_RISE: return cur & ~prev;
            EDGE_FALL: return ~cur & prev;
            EDGE_ANY:  return cur ^ prev;
            default:   return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/input_pio_debounce.sv
// rtl/input_pio_debounce.sv - one-bit two-flop synchroniser with debounce filter when INPUT_PIO_DEBOUNCE_EN is defined
module input_pio_debounce #(
    parameter int DEBOUNCE_CYCLES = 1000
) (
    input  logic clk,
    input  logic reset_n,
    input  logic din,
    output logic dout
);

    logic sync_q1;
    logic sync_q2;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync_q1 <= 1'b0;
            sync_q2 <= 1'b0;
        end else begin
            sync_q1 <= din;
            sync_q2 <= sync_q1;
        end
    end

`ifdef INPUT_PIO_DEBOUNCE_EN
    localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic [CNT_W-1:0] cnt;
    logic             filt_q;

    // The filter only moves after DEBOUNCE_CYCLES consecutive disagreeing samples.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt    <= '0;
            filt_q <= 1'b0;
        end else if (sync_q2 != filt_q) begin
            if (cnt == CNT_LAST) begin
                filt_q <= sync_q2;
                cnt    <= '0;
            end else begin
                cnt <= cnt + CNT_W'(1);
            end
        end else begin
            cnt <= '0;
        end
    end

    assign dout = filt_q;
`else
    assign dout = sync_q2;
`endif

endmodule

// File: rtl/input_pio_irq.sv
// rtl/input_pio_irq.sv - Avalon-MM input PIO with edge capture and maskable irq; debounce via INPUT_PIO_DEBOUNCE_EN
module input_pio_irq
    import input_pio_pkg::*;
#(
    parameter int WIDTH           = 18,
    parameter int DEBOUNCE_CYCLES = 1000,
    parameter int EDGE_MODE       = 0
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [1:0]       address,
    input  logic             chipselect,
    input  logic             write_n,
    input  logic [WIDTH-1:0] writedata,
    output logic [WIDTH-1:0] readdata,
    input  logic [WIDTH-1:0] in_port,
    output logic             irq
);

    localparam edge_mode_e MODE = edge_mode_e'(2'(EDGE_MODE));

    logic [WIDTH-1:0] filt;
    logic [WIDTH-1:0] filt_d;
    logic [WIDTH-1:0] edges;
    logic [WIDTH-1:0] cap;
    logic [WIDTH-1:0] mask;
    logic [WIDTH-1:0] cap_clr;
    logic [WIDTH-1:0] rd_mux;
    logic             wr_en;

    for (genvar g = 0; g < WIDTH; g++) begin : g_bit
        input_pio_debounce #(
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
        ) u_debounce (
            .clk     (clk),
            .reset_n (reset_n),
            .din     (in_port[g]),
            .dout    (filt[g])
        );
        assign edges[g] = edge_hit(filt[g], filt_d[g], MODE);
    end

    assign wr_en   = chipselect & ~write_n;
    assign cap_clr = (wr_en && address == ADDR_EDGECAP) ? writedata : '0;

    always_comb begin
        rd_mux = '0;
        case (address)
            ADDR_DATA:    rd_mux = filt;
            ADDR_IRQMASK: rd_mux = mask;
            ADDR_EDGECAP: rd_mux = cap;
            default:      rd_mux = '0;
        endcase
    end

    // A new edge wins over a write-1-clear landing on the same bit.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            filt_d   <= '0;
            cap      <= '0;
            mask     <= '0;
            irq      <= 1'b0;
            readdata <= '0;
        end else begin
            filt_d   <= filt;
            cap      <= (cap & ~cap_clr) | edges;
            irq      <= |(cap & mask);
            readdata <= rd_mux;
            if (wr_en && address == ADDR_IRQMASK) begin
                mask <= writedata;
            end
        end
    end

endmodule

// File: tb/tb_input_pio_irq.sv
// tb/tb_input_pio_irq.sv - self-checking bench for input_pio_irq across rise/fall/any edge modes
module tb_input_pio_irq;
    import input_pio_pkg::*;

    localparam int W  = 18;
    localparam int D  = 8;
`ifdef INPUT_PIO_DEBOUNCE_EN
    localparam bit DEB = 1'b1;
`else
    localparam bit DEB = 1'b0;
`endif
    localparam int LAT = DEB ? D + 3 : 3;
    localparam int HN  = D + 2;
    localparam logic [W-1:0] ALL1 = {W{1'b1}};

    logic         clk = 1'b0;
    logic         reset_n = 1'b0;
    logic [1:0]   address = 2'd0;
    logic         chipselect = 1'b0;
    logic         write_n = 1'b1;
    logic [W-1:0] writedata = '0;
    logic [W-1:0] in_port = '0;
    logic [W-1:0] rd_o [3];
    logic         irq_o [3];

    always #5 clk = ~clk;

    for (genvar m = 0; m < 3; m++) begin : g_dut
        input_pio_irq #(
            .WIDTH(W),
            .DEBOUNCE_CYCLES(D),
            .EDGE_MODE(m)
        ) u_dut (
            .clk        (clk),
            .reset_n    (reset_n),
            .address    (address),
            .chipselect (chipselect),
            .write_n    (write_n),
            .writedata  (writedata),
            .readdata   (rd_o[m]),
            .in_port    (in_port),
            .irq        (irq_o[m])
        );
    end

    // Reference model: state after each clock edge, derived from the input history.
    logic [W-1:0] hist [HN];
    logic [W-1:0] m_filt, m_filt_d, m_mask;
    logic [W-1:0] m_cap [3];
    logic [W-1:0] m_rd [3];
    logic         m_irq [3];

    int tests = 0;
    int fails = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < HN; i++) hist[i] = '0;
        m_filt = '0; m_filt_d = '0; m_mask = '0;
        for (int m = 0; m < 3; m++) begin
            m_cap[m] = '0; m_rd[m] = '0; m_irq[m] = 1'b0;
        end
    endtask

    task automatic model_edge();
        logic [W-1:0] rise, fall, ev, clr;
        bit           we, all_diff;
        if (!reset_n) return;
        we   = chipselect && !write_n;
        clr  = (we && address == 2'd3) ? writedata : '0;
        rise = m_filt & ~m_filt_d;
        fall = ~m_filt & m_filt_d;
        for (int m = 0; m < 3; m++) begin
            case (address)
                2'd0:    m_rd[m] = m_filt;
                2'd1:    m_rd[m] = m_mask;
                2'd3:    m_rd[m] = m_cap[m];
                default: m_rd[m] = '0;
            endcase
            m_irq[m] = |(m_cap[m] & m_mask);
            ev = (m == 0) ? rise : (m == 1) ? fall : (rise | fall);
            m_cap[m] = (m_cap[m] & ~clr) | ev;
        end
        if (we && address == 2'd1) m_mask = writedata;
        m_filt_d = m_filt;
        for (int i = HN - 1; i > 0; i--) hist[i] = hist[i-1];
        hist[0] = in_port;
        if (!DEB) begin
            m_filt = hist[1];
        end else begin
            for (int b = 0; b < W; b++) begin
                all_diff = 1'b1;
                for (int k = 2; k <= D + 1; k++)
                    if (hist[k][b] == m_filt[b]) all_diff = 1'b0;
                if (all_diff) m_filt[b] = ~m_filt[b];
            end
        end
    endtask

    task automatic check_all();
        for (int m = 0; m < 3; m++) begin
            check($sformatf("model_rd_mode%0d", m), 32'(rd_o[m]), 32'(m_rd[m]));
            check($sformatf("model_irq_mode%0d", m), 32'(irq_o[m]), 32'(m_irq[m]));
        end
    endtask

    task automatic tick();
        @(posedge clk);
        model_edge();
        #1;
        check_all();
    endtask

    task automatic bus_write(input logic [1:0] a, input logic [W-1:0] d);
        chipselect = 1'b1; write_n = 1'b0; address = a; writedata = d;
        tick();
        chipselect = 1'b0; write_n = 1'b1;
    endtask

    typedef struct {
        logic [W-1:0] in_val;
        bit           cs;
        bit           wr;
        logic [1:0]   waddr;
        logic [W-1:0] wdata;
        logic [1:0]   raddr;
        logic [W-1:0] exp_rd;
        bit           exp_irq;
    } vec_t;

    vec_t vt [13];

    initial begin
        // Expectations are for the rising-edge instance.
        vt[0]  = '{18'h00000, 1, 0, 2'd0, 18'h00000, 2'd0, 18'h00000, 0};
        vt[1]  = '{18'h3FFFF, 1, 0, 2'd0, 18'h00000, 2'd0, 18'h3FFFF, 0};
        vt[2]  = '{18'h3FFFF, 1, 0, 2'd0, 18'h00000, 2'd3, 18'h3FFFF, 0};
        vt[3]  = '{18'h3FFFF, 1, 1, 2'd1, 18'h00001, 2'd1, 18'h00001, 1};
        vt[4]  = '{18'h3FFFF, 1, 1, 2'd3, 18'h3FFFF, 2'd3, 18'h00000, 0};
        vt[5]  = '{18'h00000, 1, 0, 2'd0, 18'h00000, 2'd3, 18'h00000, 0};
        vt[6]  = '{18'h00008, 1, 1, 2'd1, 18'h00000, 2'd3, 18'h00008, 0};
        vt[7]  = '{18'h00008, 1, 1, 2'd1, 18'h00008, 2'd3, 18'h00008, 1};
        vt[8]  = '{18'h00008, 1, 1, 2'd2, 18'h3FFFF, 2'd2, 18'h00000, 1};
        vt[9]  = '{18'h00008, 1, 1, 2'd0, 18'h3FFFF, 2'd0, 18'h00008, 1};
        vt[10] = '{18'h00008, 1, 1, 2'd3, 18'h00000, 2'd3, 18'h00008, 1};
        vt[11] = '{18'h00008, 1, 1, 2'd3, 18'h00008, 2'd3, 18'h00000, 0};
        vt[12] = '{18'h00008, 0, 1, 2'd1, 18'h00000, 2'd1, 18'h00008, 0};

        model_reset();

        // Reset held with all inputs high.
        in_port = ALL1;
        repeat (4) tick();
        check("reset_readdata", 32'(rd_o[0]), 32'h0);
        check("reset_irq", 32'(irq_o[0]), 32'h0);
        reset_n = 1'b1;
        for (int i = 1; i <= LAT; i++) begin
            tick();
            if (i == LAT - 1) check("data_latency_early", 32'(rd_o[0]), 32'h0);
            if (i == LAT)     check("data_latency", 32'(rd_o[0]), 32'(ALL1));
        end

        for (int v = 0; v < 13; v++) begin
            in_port = vt[v].in_val;
            chipselect = vt[v].cs; write_n = !vt[v].wr;
            address = vt[v].waddr; writedata = vt[v].wdata;
            tick();
            chipselect = 1'b0; write_n = 1'b1; address = vt[v].raddr;
            repeat (LAT + 2) tick();
            check($sformatf("vec%0d_rd", v), 32'(rd_o[0]), 32'(vt[v].exp_rd));
            check($sformatf("vec%0d_irq", v), 32'(irq_o[0]), 32'(vt[v].exp_irq));
        end

        // Clear and new edge on bit 2 in the same cycle: set wins.
        in_port = '0;
        repeat (LAT + 2) tick();
        bus_write(2'd3, ALL1);
        in_port = 18'h00004;
        repeat (LAT - 1) tick();
        bus_write(2'd3, 18'h00004);
        address = 2'd3;
        tick();
        check("set_beats_clear", 32'(rd_o[0]), 32'h4);
        bus_write(2'd3, 18'h00004);
        tick();
        check("clear_after", 32'(rd_o[0]), 32'h0);

`ifdef INPUT_PIO_DEBOUNCE_EN
        // Bounce shorter than the debounce window is filtered out.
        in_port = 18'h00005;
        repeat (D - 3) tick();
        in_port = 18'h00004;
        address = 2'd0;
        repeat (LAT + 2) tick();
        check("bounce_data", 32'(rd_o[0]), 32'h4);
        address = 2'd3;
        tick();
        check("bounce_cap", 32'(rd_o[0]), 32'h0);
`endif

        // Any-edge mode captures both the rise and the fall on bit 5.
        in_port = '0;
        repeat (LAT + 2) tick();
        bus_write(2'd3, ALL1);
        in_port = 18'h00020;
        address = 2'd3;
        repeat (LAT + 2) tick();
        check("any_rise", 32'(rd_o[2]), 32'h20);
        bus_write(2'd3, ALL1);
        in_port = '0;
        address = 2'd3;
        repeat (LAT + 2) tick();
        check("any_fall", 32'(rd_o[2]), 32'h20);
        check("rise_ignores_fall", 32'(rd_o[0]), 32'h0);
        check("fall_mode_fall", 32'(rd_o[1]), 32'h20);
        address = 2'd2;
        tick();
        check("reserved_reads_0", 32'(rd_o[2]), 32'h0);

        // Asynchronous reset in the middle of operation.
        bus_write(2'd1, 18'h00020);
        address = 2'd3;
        repeat (2) tick();
        check("irq_before_reset", 32'(irq_o[2]), 32'h1);
        reset_n = 1'b0;
        model_reset();
        #1;
        check("async_reset_rd", 32'(rd_o[2]), 32'h0);
        check("async_reset_irq", 32'(irq_o[2]), 32'h0);
        repeat (2) tick();
        reset_n = 1'b1;
        repeat (LAT + 2) tick();
        check("no_edge_on_release", 32'(rd_o[2]), 32'h0);

        // Randomised traffic against the model.
        for (int c = 0; c < 600; c++) begin
            if ($urandom_range(0, 11) == 0) in_port = W'($urandom);
            chipselect = 1'($urandom);
            write_n = ($urandom_range(0, 3) != 0);
            address = 2'($urandom);
            writedata = ($urandom_range(0, 1) == 0) ? W'($urandom) : ALL1;
            tick();
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
